// File: rtl/cnn_stage_sequencer.sv
// Frame timing controller for the CNN pipeline: walks a (line, count) raster per frame and
// issues one-cycle latch strobes to each inter-layer handoff register at its configured position.
module cnn_stage_sequencer #(
    parameter int unsigned                  NUM_STAGES   = 6,
    parameter int unsigned                  ROW_LEN      = 26,
    parameter int unsigned                  NUM_ROWS     = 30,
    parameter logic [NUM_STAGES*5-1:0]      STAGE_LINES  = {5'd30, 5'd24, 5'd18, 5'd12, 5'd6, 5'd1},
    parameter logic [NUM_STAGES*5-1:0]      STAGE_COUNTS = {5'd25, 5'd10, 5'd5, 5'd20, 5'd16, 5'd0},
    parameter int unsigned                  FLUSH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [4:0]            line,
    output logic [4:0]            count,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            frame_cnt,
    output logic                  err_overrun
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    localparam logic [4:0] LastCount = 5'(ROW_LEN - 1);
    localparam logic [4:0] LastLine  = 5'(NUM_ROWS);
    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [4:0] line_q, line_d;
    logic [4:0] count_q, count_d;
    logic [3:0] flush_q, flush_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    logic advance;
    logic last_pos;
    logic active;

    assign advance  = (state_q == StRun) && !hold;
    assign last_pos = (line_q == LastLine) && (count_q == LastCount);
    assign active   = (state_q == StRun) || (state_q == StFlush);

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        count_d     = count_q;
        flush_d     = flush_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    line_d  = 5'd1;
                    count_d = 5'd0;
                end
            end
            StRun: begin
                if (!hold) begin
                    // The final position keeps line/count parked until the next frame entry.
                    if (last_pos) begin
                        if (FLUSH_CYCLES == 0) begin
                            state_d     = StDone;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end else begin
                            state_d = StFlush;
                            flush_d = FlushLoad;
                        end
                    end else if (count_q == LastCount) begin
                        count_d = 5'd0;
                        line_d  = line_q + 5'd1;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            StFlush: begin
                if (flush_q == 4'd0) begin
                    state_d     = StDone;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    flush_d = flush_q - 4'd1;
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StRun;
                    line_d  = 5'd1;
                    count_d = 5'd0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            line_q      <= 5'd1;
            count_q     <= 5'd0;
            flush_q     <= 4'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            count_q     <= count_d;
            flush_q     <= flush_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Strobes are gated by rst so an aborting reset never lets the current position fire.
    always_comb begin
        stage_en = '0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            stage_en[i] = advance && !rst &&
                          (line_q == STAGE_LINES[5*i +: 5]) &&
                          (count_q == STAGE_COUNTS[5*i +: 5]);
        end
    end

    assign err_overrun = start && !rst && active;
    assign busy        = active;
    assign done        = (state_q == StDone);
    assign line        = line_q;
    assign count       = count_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Scoreboard bench: a position-index reference model predicts strobe/done/overrun events which a
// negedge monitor matches against two sequencer instances (default and a tiny zero-flush config).
module tb_cnn_stage_sequencer;

    typedef struct packed {
        int              rows;
        int              rlen;
        int              flush;
        int              nst;
        logic [7:0][4:0] sl;
        logic [7:0][4:0] sc;
    } cfg_t;

    typedef struct packed {
        int mode;
        int p;
        int fl;
        int fc;
    } mst_t;

    typedef struct packed {
        int         cyc;
        logic [7:0] en;
        logic       done;
        logic       busy;
        int         line;
        int         count;
        int         fc;
        logic       err;
    } exp_t;

    localparam int ModeIdle  = 0;
    localparam int ModeRun   = 1;
    localparam int ModeFlush = 2;
    localparam int ModeDone  = 3;

    logic       clk = 1'b0;
    logic       start_a = 1'b0, hold_a = 1'b0, rst_a = 1'b1;
    logic       start_b = 1'b0, hold_b = 1'b0, rst_b = 1'b1;
    logic [5:0] stage_en_a;
    logic [3:0] stage_en_b;
    logic [4:0] line_a, count_a, line_b, count_b;
    logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [7:0] frame_cnt_a, frame_cnt_b;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   hc = 0;
    cfg_t cfg_a, cfg_b;
    mst_t ms_a, ms_b;
    exp_t q_a[$];
    exp_t q_b[$];
    int   fire_a[6];
    int   done_cyc_a[$];
    int   la[6] = '{1, 6, 12, 18, 24, 30};
    int   ca[6] = '{0, 16, 20, 5, 10, 25};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cnn_stage_sequencer dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .hold(hold_a), .stage_en(stage_en_a),
        .line(line_a), .count(count_a), .busy(busy_a), .done(done_a), .frame_cnt(frame_cnt_a),
        .err_overrun(err_a)
    );

    // Stages 0 and 1 share (1,1); stage 3 sits on line 3, outside the 2-line frame.
    cnn_stage_sequencer #(
        .NUM_STAGES(4), .ROW_LEN(3), .NUM_ROWS(2),
        .STAGE_LINES({5'd3, 5'd2, 5'd1, 5'd1}), .STAGE_COUNTS({5'd0, 5'd2, 5'd1, 5'd1}),
        .FLUSH_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .hold(hold_b), .stage_en(stage_en_b),
        .line(line_b), .count(count_b), .busy(busy_b), .done(done_b), .frame_cnt(frame_cnt_b),
        .err_overrun(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the frame is a linear position index p = (line-1)*rlen + count.
    task automatic step(input cfg_t c, input mst_t s, input bit st, input bit hd, input bit rs,
                        output mst_t n, output exp_t e);
        int total;
        int l;
        int k;
        total  = c.rows * c.rlen;
        e      = '0;
        e.cyc  = cyc;
        e.line = s.p / c.rlen + 1;
        e.count = s.p % c.rlen;
        e.fc   = s.fc;
        e.busy = (s.mode == ModeRun) || (s.mode == ModeFlush);
        e.done = (s.mode == ModeDone);
        e.err  = st && e.busy && !rs;
        for (int i = 0; i < c.nst; i++) begin
            l = int'(c.sl[i]);
            k = int'(c.sc[i]);
            if (s.mode == ModeRun && !hd && !rs && k < c.rlen && l >= 1 && l <= c.rows &&
                s.p == (l - 1) * c.rlen + k)
                e.en[i] = 1'b1;
        end
        n = s;
        if (rs) begin
            n = '0;
        end else begin
            case (s.mode)
                ModeIdle: if (st) begin n.mode = ModeRun; n.p = 0; end
                ModeRun: begin
                    if (!hd) begin
                        if (s.p == total - 1) begin
                            if (c.flush == 0) begin
                                n.mode = ModeDone;
                                n.fc   = (s.fc + 1) % 256;
                            end else begin
                                n.mode = ModeFlush;
                                n.fl   = c.flush;
                            end
                        end else begin
                            n.p = s.p + 1;
                        end
                    end
                end
                ModeFlush: begin
                    n.fl = s.fl - 1;
                    if (n.fl == 0) begin
                        n.mode = ModeDone;
                        n.fc   = (s.fc + 1) % 256;
                    end
                end
                default: begin
                    if (st) begin n.mode = ModeRun; n.p = 0; end
                    else n.mode = ModeIdle;
                end
            endcase
        end
    endtask

    // Called #1 after a rising edge; applies one cycle of inputs to both DUTs.
    task automatic drive(input bit sa, input bit ha, input bit ra,
                         input bit sb, input bit hb, input bit rb);
        mst_t n;
        exp_t e;
        start_a = sa; hold_a = ha; rst_a = ra;
        start_b = sb; hold_b = hb; rst_b = rb;
        step(cfg_a, ms_a, sa, ha, ra, n, e);
        ms_a = n;
        if (e.en != 0 || e.done || e.err) q_a.push_back(e);
        step(cfg_b, ms_b, sb, hb, rb, n, e);
        ms_b = n;
        if (e.en != 0 || e.done || e.err) q_b.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int w, input logic [7:0] en, input logic dn, input logic bs,
                       input logic [4:0] ln, input logic [4:0] cn, input logic [7:0] fc,
                       input logic er);
        exp_t e;
        if (cyc == 0) return;
        if (!(|en === 1'b1 || dn === 1'b1 || er === 1'b1)) return;
        tests++;
        if ((w == 0 && q_a.size() == 0) || (w == 1 && q_b.size() == 0)) begin
            fails++;
            $display("FAIL dut%0d_unexpected: cycle %0d en=%b done=%b err=%b, expected no event",
                     w, cyc, en, dn, er);
            return;
        end
        e = (w == 0) ? q_a.pop_front() : q_b.pop_front();
        if (e.cyc != cyc || e.en !== en || e.done !== dn || e.busy !== bs || e.err !== er ||
            e.line !== {27'b0, ln} || e.count !== {27'b0, cn} || e.fc !== {24'b0, fc}) begin
            fails++;
            $display("FAIL dut%0d_event: got cyc=%0d en=%b done=%b busy=%b err=%b pos=(%0d,%0d) fc=%0d, expected cyc=%0d en=%b done=%b busy=%b err=%b pos=(%0d,%0d) fc=%0d",
                     w, cyc, en, dn, bs, er, ln, cn, fc,
                     e.cyc, e.en, e.done, e.busy, e.err, e.line, e.count, e.fc);
        end
        if (w == 0) begin
            for (int i = 0; i < 6; i++) if (en[i] === 1'b1 && fire_a[i] < 0) fire_a[i] = cyc;
            if (dn === 1'b1) done_cyc_a.push_back(cyc);
        end
    endtask

    always @(negedge clk) begin
        mon(0, {2'b0, stage_en_a}, done_a, busy_a, line_a, count_a, frame_cnt_a, err_a);
        mon(1, {4'b0, stage_en_b}, done_b, busy_b, line_b, count_b, frame_cnt_b, err_b);
    end

    // mode 0: quiet; 1: 3-cycle hold at (6,16); 2: random hold and stray starts.
    task automatic run_a(input int bound, input int mode);
        bit st;
        bit hd;
        int k;
        k = 0;
        while (ms_a.mode != ModeIdle && k < bound) begin
            st = 1'b0;
            hd = 1'b0;
            if (mode == 1 && ms_a.mode == ModeRun && ms_a.p == 5 * 26 + 16 && hc < 3) begin
                hd = 1'b1;
                hc++;
            end
            if (mode == 2) begin
                hd = ($urandom % 4) == 0;
                st = (ms_a.mode == ModeRun || ms_a.mode == ModeFlush) && ($urandom % 16) == 0;
            end
            drive(st, hd, 1'b0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        check("frame_a_timeout", {31'b0, ms_a.mode != ModeIdle}, 32'd0);
    endtask

    initial begin
        int s;
        int frames;
        int k;
        cfg_a = '0;
        cfg_a.rows = 30; cfg_a.rlen = 26; cfg_a.flush = 4; cfg_a.nst = 6;
        for (int i = 0; i < 6; i++) begin
            cfg_a.sl[i] = 5'(la[i]);
            cfg_a.sc[i] = 5'(ca[i]);
            fire_a[i]   = -1;
        end
        cfg_b = '0;
        cfg_b.rows = 2; cfg_b.rlen = 3; cfg_b.flush = 0; cfg_b.nst = 4;
        cfg_b.sl[0] = 5'd1; cfg_b.sc[0] = 5'd1;
        cfg_b.sl[1] = 5'd1; cfg_b.sc[1] = 5'd1;
        cfg_b.sl[2] = 5'd2; cfg_b.sc[2] = 5'd2;
        cfg_b.sl[3] = 5'd3; cfg_b.sc[3] = 5'd0;
        ms_a = '0;
        ms_b = '0;

        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        start_a = 1'b0; hold_a = 1'b0; rst_a = 1'b0;
        start_b = 1'b0; hold_b = 1'b0; rst_b = 1'b0;
        #1;
        check("rst_line", line_a, 1);
        check("rst_count", count_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_frame_cnt", frame_cnt_a, 0);
        check("rst_stage_en", stage_en_a, 0);
        check("rst_err", err_a, 0);
        check("rst_b_busy", busy_b, 0);

        // Frame 1: start during cycle 10, no hold.
        while (cyc < 10) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        s = cyc;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("busy_rise", busy_a, 1);
        check("first_line", line_a, 1);
        check("first_count", count_a, 0);
        run_a(900, 0);
        for (int i = 0; i < 6; i++)
            check($sformatf("fire_stage%0d", i), fire_a[i], s + 1 + (la[i] - 1) * 26 + ca[i]);
        check("done_cycle", done_cyc_a.size() > 0 ? done_cyc_a[$] : -1, s + 785);
        check("frame_cnt_1", frame_cnt_a, 1);

        // Frame 2: three hold cycles at (6,16) push done out by exactly three cycles.
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        s = cyc;
        hc = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_a(1000, 1);
        check("hold_done_cycle", done_cyc_a.size() > 0 ? done_cyc_a[$] : -1, s + 788);
        check("frame_cnt_2", frame_cnt_a, 2);

        // Frame 3: random holds and stray starts.
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_a(2500, 2);

        // Frame 4: reset at (18,5) aborts; then a fresh frame restarts at (1,0).
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (!(ms_a.mode == ModeRun && ms_a.p == 17 * 26 + 5) && k < 600) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_line", line_a, 1);
        check("abort_count", count_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_frame_cnt", frame_cnt_a, 0);
        repeat (40) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_busy", busy_a, 1);
        check("restart_line", line_a, 1);
        check("restart_count", count_a, 0);
        run_a(900, 0);
        check("restart_frame_cnt", frame_cnt_a, 1);

        // Small instance: start held high through more than 256 back-to-back frames.
        frames = 0;
        k = 0;
        while (frames < 257 && k < 4000) begin
            if (ms_b.mode == ModeDone) frames++;
            drive(1'b0, 1'b0, 1'b0, 1'b1, ($urandom % 8) == 0, 1'b0);
            k++;
        end
        check("b_frames_reached", frames, 257);
        k = 0;
        while (ms_b.mode != ModeIdle && k < 40) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        check("b_frame_cnt_wrap", frame_cnt_b, 32'(ms_b.fc));
        check("b_idle", busy_b, 0);

        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("q_a_drained", q_a.size(), 0);
        check("q_b_drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
